// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch (IF) and data (MEM) requesters.
// Optional IF anti-starvation counter is enabled by defining ARB_FAIR_EN.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusyI = 2'd1;
    localparam logic [1:0] StBusyD = 2'd2;

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic if_elig, dm_elig, force_if, grant_dm, grant_if;

    // A requester in its ack cycle still holds req; masking it avoids a duplicate grant.
    assign if_elig  = if_req_i & ~if_ack_q;
    assign dm_elig  = dm_req_i & ~dm_ack_q;
    assign grant_dm = (state_q == StIdle) & dm_elig & ~force_if;
    assign grant_if = (state_q == StIdle) & if_elig & ~grant_dm;

`ifdef ARB_FAIR_EN
    localparam int unsigned StW = $clog2(STARVE_MAX + 1);

    logic [StW-1:0] starve_q, starve_d;

    assign force_if = if_elig & (starve_q >= StW'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (grant_dm && if_elig) begin
            starve_d = starve_q + 1'b1;
        end else if (grant_if) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_max;

    assign force_if          = 1'b0;
    assign unused_starve_max = (STARVE_MAX != 0);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            StIdle: begin
                if (grant_dm) begin
                    state_d = StBusyD;
                    addr_d  = dm_addr_i;
                    we_d    = dm_we_i;
                    wdata_d = dm_wdata_i;
                    cnt_d   = CntW'(MEM_LAT - 1);
                end else if (grant_if) begin
                    state_d = StBusyI;
                    addr_d  = if_addr_i;
                    we_d    = 1'b0;
                    cnt_d   = CntW'(MEM_LAT - 1);
                end
            end
            StBusyI, StBusyD: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    if (state_q == StBusyI) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end else begin
                        dm_ack_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_en_o    = (state_q != StIdle);
    assign mem_we_o    = (state_q == StBusyD) & we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign stall_if_o  = if_req_i & ~if_ack_q;
    assign stall_mem_o = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus randomized traffic against a
// cycle-numbered reference model of the arbitration rules.
module tb_unified_mem_arbiter;

    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        stall_if;
    logic        stall_mem;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    unified_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_rdata_o (if_rdata),
        .if_ack_o   (if_ack),
        .dm_req_i   (dm_req),
        .dm_we_i    (dm_we),
        .dm_addr_i  (dm_addr),
        .dm_wdata_i (dm_wdata),
        .dm_rdata_o (dm_rdata),
        .dm_ack_o   (dm_ack),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .stall_if_o (stall_if),
        .stall_mem_o(stall_mem)
    );

    // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
    task automatic cyc_start;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
        if_addr = 32'h1234; dm_addr = 32'h5678; dm_wdata = 32'hFFFF_FFFF; mem_rdata = 32'hA5A5_A5A5;
        repeat (3) cyc_start;
        @(negedge clk_i);
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset mem_en got %0h want 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset mem_we got %0h want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr got %0h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset mem_wdata got %0h want 0", mem_wdata); end
        checks++; if ({if_ack, dm_ack} !== 2'b00) begin errors++; $display("FAIL reset acks got %b want 00", {if_ack, dm_ack}); end
        checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset if_rdata got %0h want 0", if_rdata); end
        checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL reset dm_rdata got %0h want 0", dm_rdata); end
        checks++; if ({stall_if, stall_mem} !== 2'b11) begin errors++; $display("FAIL reset stalls got %b want 11", {stall_if, stall_mem}); end
        cyc_start;
        rst_n = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    endtask

    task automatic test_fetch;
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h00A0_0093;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk_i);
            checks++; if (mem_en !== (k == 1 || k == 2)) begin errors++; $display("FAIL fetch mem_en k=%0d got %0h want %0h", k, mem_en, (k == 1 || k == 2)); end
            checks++; if (if_ack !== (k == 3)) begin errors++; $display("FAIL fetch if_ack k=%0d got %0h want %0h", k, if_ack, (k == 3)); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch mem_we k=%0d got %0h want 0", k, mem_we); end
            if (k == 1 || k == 2) begin
                checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fetch mem_addr k=%0d got %0h want 10", k, mem_addr); end
            end
            if (k == 3) begin
                checks++; if (if_rdata !== 32'h00A0_0093) begin errors++; $display("FAIL fetch if_rdata got %0h want 00a00093", if_rdata); end
            end
            checks++; if (stall_if !== (k < 3)) begin errors++; $display("FAIL fetch stall_if k=%0d got %0h want %0h", k, stall_if, (k < 3)); end
            cyc_start;
            if (k == 3) if_req = 1'b0;
        end
    endtask

    task automatic test_store;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h1234_5678;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk_i);
            checks++; if (mem_en !== (k == 1 || k == 2)) begin errors++; $display("FAIL store mem_en k=%0d got %0h want %0h", k, mem_en, (k == 1 || k == 2)); end
            checks++; if (mem_we !== (k == 1 || k == 2)) begin errors++; $display("FAIL store mem_we k=%0d got %0h want %0h", k, mem_we, (k == 1 || k == 2)); end
            checks++; if (dm_ack !== (k == 3)) begin errors++; $display("FAIL store dm_ack k=%0d got %0h want %0h", k, dm_ack, (k == 3)); end
            if (k == 1 || k == 2) begin
                checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL store mem_addr k=%0d got %0h want 40", k, mem_addr); end
                checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store mem_wdata k=%0d got %0h want deadbeef", k, mem_wdata); end
            end
            checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL store dm_rdata k=%0d got %0h want 0", k, dm_rdata); end
            cyc_start;
            if (k == 0) dm_wdata = 32'h0BAD_0BAD;
            if (k == 3) begin dm_req = 1'b0; dm_we = 1'b0; end
        end
    endtask

    task automatic test_conflict;
        if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        for (int k = 0; k <= 7; k++) begin
            mem_rdata = 32'hC0DE_0000 | k;
            @(negedge clk_i);
            checks++; if (dm_ack !== (k == 3)) begin errors++; $display("FAIL conflict dm_ack k=%0d got %0h want %0h", k, dm_ack, (k == 3)); end
            checks++; if (if_ack !== (k == 6)) begin errors++; $display("FAIL conflict if_ack k=%0d got %0h want %0h", k, if_ack, (k == 6)); end
            checks++; if (stall_if !== (k <= 5)) begin errors++; $display("FAIL conflict stall_if k=%0d got %0h want %0h", k, stall_if, (k <= 5)); end
            checks++; if (stall_mem !== (k <= 2)) begin errors++; $display("FAIL conflict stall_mem k=%0d got %0h want %0h", k, stall_mem, (k <= 2)); end
            if (k == 1 || k == 2) begin
                checks++; if (mem_addr !== 32'h80) begin errors++; $display("FAIL conflict dm mem_addr k=%0d got %0h want 80", k, mem_addr); end
            end
            if (k == 4 || k == 5) begin
                checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL conflict if mem_addr k=%0d got %0h want 20", k, mem_addr); end
            end
            if (k == 3) begin
                checks++; if (dm_rdata !== 32'hC0DE_0002) begin errors++; $display("FAIL conflict dm_rdata got %0h want c0de0002", dm_rdata); end
            end
            if (k == 6) begin
                checks++; if (if_rdata !== 32'hC0DE_0005) begin errors++; $display("FAIL conflict if_rdata got %0h want c0de0005", if_rdata); end
            end
            cyc_start;
            if (k == 3) dm_req = 1'b0;
            if (k == 6) if_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] prev_if_rdata;
        prev_if_rdata = if_rdata;
        if_req = 1'b1; if_addr = 32'h30; mem_rdata = 32'h7777_7777;
        cyc_start;
        @(negedge clk_i);
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid busy mem_en got %0h want 1", mem_en); end
        rst_n = 1'b0;
        @(posedge clk_i);
        #1;
        rst_n = 1'b1; if_req = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk_i);
            checks++; if ({mem_en, mem_we, if_ack, dm_ack} !== 4'b0) begin errors++; $display("FAIL rstmid ctrl k=%0d got %b want 0000", k, {mem_en, mem_we, if_ack, dm_ack}); end
            checks++; if ({mem_addr, if_rdata, dm_rdata} !== 96'h0) begin errors++; $display("FAIL rstmid data k=%0d got %0h want 0 (prev if_rdata %0h)", k, {mem_addr, if_rdata, dm_rdata}, prev_if_rdata); end
            cyc_start;
        end
    endtask

    task automatic test_regrant;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; mem_rdata = 32'h5555_0000;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk_i);
            checks++; if (dm_ack !== (k == 3 || k == 7)) begin errors++; $display("FAIL regrant dm_ack k=%0d got %0h want %0h", k, dm_ack, (k == 3 || k == 7)); end
            checks++; if (mem_en !== (k == 1 || k == 2 || k == 5 || k == 6)) begin errors++; $display("FAIL regrant mem_en k=%0d got %0h want %0h", k, mem_en, (k == 1 || k == 2 || k == 5 || k == 6)); end
            cyc_start;
            if (k == 7) dm_req = 1'b0;
        end
    endtask

    // Reference: an access granted in cycle g owns the port in cycles g+1..g+MEM_LAT and
    // acks in g+MEM_LAT+1.
    task automatic test_random;
        int          owner;  // 0 none, 1 fetch, 2 data
        int          g;
        int          starve;
        logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
        logic        m_we, m_if_ack, m_dm_ack, n_if_ack, n_dm_ack, ie, de, force_if;
        owner = 0; g = 0; starve = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
        m_if_rdata = '0; m_dm_rdata = '0; m_if_ack = 1'b0; m_dm_ack = 1'b0;
        rst_n = 1'b0;
        cyc_start;
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            if_req    = if_req ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
            dm_req    = dm_req ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
            dm_we     = $urandom_range(0, 1) == 1;
            if_addr   = $urandom;
            dm_addr   = $urandom;
            dm_wdata  = $urandom;
            mem_rdata = $urandom;
            @(negedge clk_i);
            checks++; if (if_ack !== m_if_ack) begin errors++; $display("FAIL rand if_ack c=%0d got %0h want %0h", c, if_ack, m_if_ack); end
            checks++; if (dm_ack !== m_dm_ack) begin errors++; $display("FAIL rand dm_ack c=%0d got %0h want %0h", c, dm_ack, m_dm_ack); end
            checks++; if (if_rdata !== m_if_rdata) begin errors++; $display("FAIL rand if_rdata c=%0d got %0h want %0h", c, if_rdata, m_if_rdata); end
            checks++; if (dm_rdata !== m_dm_rdata) begin errors++; $display("FAIL rand dm_rdata c=%0d got %0h want %0h", c, dm_rdata, m_dm_rdata); end
            checks++; if (mem_en !== (owner != 0)) begin errors++; $display("FAIL rand mem_en c=%0d got %0h want %0h", c, mem_en, (owner != 0)); end
            checks++; if (mem_we !== (owner == 2 && m_we)) begin errors++; $display("FAIL rand mem_we c=%0d got %0h want %0h", c, mem_we, (owner == 2 && m_we)); end
            checks++; if (stall_if !== (if_req && !m_if_ack)) begin errors++; $display("FAIL rand stall_if c=%0d got %0h want %0h", c, stall_if, (if_req && !m_if_ack)); end
            checks++; if (stall_mem !== (dm_req && !m_dm_ack)) begin errors++; $display("FAIL rand stall_mem c=%0d got %0h want %0h", c, stall_mem, (dm_req && !m_dm_ack)); end
            if (owner != 0) begin
                checks++; if (mem_addr !== m_addr) begin errors++; $display("FAIL rand mem_addr c=%0d got %0h want %0h", c, mem_addr, m_addr); end
            end
            if (owner == 2 && m_we) begin
                checks++; if (mem_wdata !== m_wdata) begin errors++; $display("FAIL rand mem_wdata c=%0d got %0h want %0h", c, mem_wdata, m_wdata); end
            end
            n_if_ack = 1'b0;
            n_dm_ack = 1'b0;
            if (!rst_n) begin
                owner = 0; starve = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
                m_if_rdata = '0; m_dm_rdata = '0;
            end else if (owner != 0) begin
                if (c == g + MEM_LAT) begin
                    if (owner == 1) begin
                        n_if_ack = 1'b1; m_if_rdata = mem_rdata;
                    end else begin
                        n_dm_ack = 1'b1;
                        if (!m_we) m_dm_rdata = mem_rdata;
                    end
                    owner = 0;
                end
            end else begin
                ie = if_req && !m_if_ack;
                de = dm_req && !m_dm_ack;
`ifdef ARB_FAIR_EN
                force_if = ie && (starve >= STARVE_MAX);
`else
                force_if = 1'b0;
`endif
                if (de && !force_if) begin
                    owner = 2; g = c; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
                    if (ie) starve++;
                end else if (ie) begin
                    owner = 1; g = c; m_addr = if_addr; m_we = 1'b0; starve = 0;
                end
            end
            m_if_ack = n_if_ack;
            m_dm_ack = n_dm_ack;
            cyc_start;
        end
        if_req = 1'b0; dm_req = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store;
        test_conflict;
        test_reset_mid;
        test_regrant;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
